// File: rtl/fetch_controller.sv
// Instruction fetch controller: issues one imem request at a time and registers the returned word for decode.
// Latency: a word reaches the decode register on the edge after its response (or after the buffer frees).
// Backpressure: a stalled decode parks one response in a single-entry buffer; no new request is issued until it drains.
module fetch_controller #(
  parameter int XLEN        = 32,
  parameter int PC_SRC_BITS = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [XLEN-1:0]        pc_fetch,
  input  logic                   branch_taken_execute,
  input  logic                   jump_register_execute,
  input  logic                   stall_decode,
  output logic                   imem_req_valid,
  input  logic                   imem_req_ready,
  output logic [XLEN-1:0]        imem_req_addr,
  input  logic                   imem_resp_valid,
  input  logic [31:0]            imem_resp_data,
  output logic                   stall_fetch,
  output logic [PC_SRC_BITS-1:0] pc_source,
  output logic                   flush_decode,
  output logic                   instr_valid_decode,
  output logic [31:0]            instr_decode,
  output logic [XLEN-1:0]        pc_decode
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    WAIT   = 3'd2,
    BUFFER = 3'd3,
    DRAIN  = 3'd4
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            redirect;
  logic            out_free;
  logic            issue;
  logic            load_resp;
  logic            load_buf;
  logic            store_buf;
  logic [XLEN-1:0] pc_pending;
  logic [31:0]     buf_data;
  logic [XLEN-1:0] buf_pc;

  assign redirect      = branch_taken_execute | jump_register_execute;
  assign out_free      = ~instr_valid_decode | ~stall_decode;
  assign imem_req_addr = pc_fetch;

  // Next-PC select: a register jump wins over a taken branch.
  always_comb begin
    pc_source = PC_SRC_BITS'(0);
    if (jump_register_execute) begin
      pc_source = PC_SRC_BITS'(2);
    end else if (branch_taken_execute) begin
      pc_source = PC_SRC_BITS'(1);
    end
  end

  // Next-state and handshake decode; the PC is held unless a request is accepted or a redirect loads the target.
  always_comb begin
    state_next     = state;
    imem_req_valid = 1'b0;
    stall_fetch    = 1'b1;
    flush_decode   = 1'b0;
    issue          = 1'b0;
    load_resp      = 1'b0;
    load_buf       = 1'b0;
    store_buf      = 1'b0;
    case (state)
      IDLE: begin
        state_next = REQ;
      end
      REQ: begin
        imem_req_valid = ~redirect;
        if (!redirect && imem_req_ready) begin
          issue       = 1'b1;
          stall_fetch = 1'b0;
          state_next  = WAIT;
        end
      end
      WAIT: begin
        if (redirect) begin
          // A response in the redirect cycle retires the request; otherwise it is still in flight.
          state_next = imem_resp_valid ? REQ : DRAIN;
        end else if (imem_resp_valid) begin
          if (out_free) begin
            load_resp  = 1'b1;
            state_next = REQ;
          end else begin
            store_buf  = 1'b1;
            state_next = BUFFER;
          end
        end
      end
      BUFFER: begin
        if (redirect) begin
          state_next = REQ;
        end else if (out_free) begin
          load_buf   = 1'b1;
          state_next = REQ;
        end
      end
      DRAIN: begin
        if (imem_resp_valid) begin
          state_next = REQ;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (redirect && state != IDLE) begin
      stall_fetch  = 1'b0;
      flush_decode = 1'b1;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Pending PC, skid buffer and decode output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_pending         <= '0;
      buf_data           <= '0;
      buf_pc             <= '0;
      instr_valid_decode <= 1'b0;
      instr_decode       <= '0;
      pc_decode          <= '0;
    end else begin
      if (issue) begin
        pc_pending <= pc_fetch;
      end
      if (flush_decode) begin
        buf_data <= '0;
        buf_pc   <= '0;
      end else if (store_buf) begin
        buf_data <= imem_resp_data;
        buf_pc   <= pc_pending;
      end
      if (flush_decode) begin
        instr_valid_decode <= 1'b0;
      end else if (load_resp) begin
        instr_valid_decode <= 1'b1;
        instr_decode       <= imem_resp_data;
        pc_decode          <= pc_pending;
      end else if (load_buf) begin
        instr_valid_decode <= 1'b1;
        instr_decode       <= buf_data;
        pc_decode          <= buf_pc;
      end else if (!(instr_valid_decode && stall_decode)) begin
        instr_valid_decode <= 1'b0;
      end
    end
  end

endmodule
